// File: rtl/lagarto_pmu_pkg.sv
// Shared definitions for the Lagarto performance-monitor controller:
// register addresses, CTRL bit positions, FSM states and the request bundle.
package lagarto_pmu_pkg;

  localparam int PMU_ADDR_W = 5;
  localparam int PMU_DATA_W = 64;
  localparam int EVSEL_W    = 5;

  // Register map (word addresses)
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_OVF      = 1;
  localparam int ADDR_MASK     = 2;
  localparam int ADDR_CNT_BASE = 8;  // EVSEL_i at 8+2i, COUNT_i at 9+2i

  // CTRL register bits
  localparam int CTRL_EN  = 0;
  localparam int CTRL_FRZ = 1;
  localparam int CTRL_CLR = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESP  = 2'd1,
    CLEAR = 2'd2
  } pmu_state_e;

  typedef struct packed {
    logic                  we;
    logic [PMU_ADDR_W-1:0] addr;
    logic [PMU_DATA_W-1:0] wdata;
  } pmu_req_t;

endpackage

// File: rtl/lagarto_pmu_counter.sv
// One programmable event counter. Clear beats a software write, which beats
// an increment; ovf_o pulses when an increment wraps the all-ones value.
module lagarto_pmu_counter #(
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             reset_l,
  input  logic             inc_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count value with clear > write > increment priority
  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
      ovf_o   = &count_q;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/lagarto_pmu_ctrl.sv
// Lagarto performance-monitor controller: samples the core event vector into
// NUM_CNT programmable counters and serves a single-outstanding register port.
module lagarto_pmu_ctrl
  import lagarto_pmu_pkg::*;
#(
  parameter int NUM_EVENTS = 25,
  parameter int NUM_CNT    = 8,
  parameter int CNT_W      = 64,
  parameter int ADDR_W     = PMU_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  reset_l,
  input  logic [NUM_EVENTS-1:0] pmu_sig_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_W-1:0]     req_addr_i,
  input  logic [63:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  ovf_irq_o
);

  localparam int IDX_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  pmu_req_t                          req;
  pmu_state_e                        state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [NUM_EVENTS-1:0]             sampled_q, sampled_d;
  logic                              enable_q, enable_d;
  logic                              freeze_q, freeze_d;
  logic [NUM_CNT-1:0]                ovf_q, ovf_d;
  logic [NUM_CNT-1:0]                mask_q, mask_d;
  logic [NUM_CNT-1:0][EVSEL_W-1:0]   evsel_q, evsel_d;
  logic                              rsp_valid_q, rsp_valid_d;
  logic                              rsp_err_q, rsp_err_d;
  logic [63:0]                       rsp_rdata_q, rsp_rdata_d;
  logic                              irq_q, irq_d;

  logic [NUM_CNT-1:0][CNT_W-1:0]     count;
  logic [NUM_CNT-1:0]                cnt_inc, cnt_we, cnt_clr, cnt_ovf;
  logic [31:0]                       ev_vec;
  logic [63:0]                       rdata_mux;
  int                                cnt_off;
  logic [IDX_W-1:0]                  sel_idx;
  logic                              hit_ctrl, hit_ovf, hit_mask, hit_evsel, hit_count;
  logic                              addr_err, accept, wr, rd;

  assign req.we    = req_we_i;
  assign req.addr  = PMU_ADDR_W'(req_addr_i);
  assign req.wdata = req_wdata_i;

  assign accept = req_valid_i & (state_q == IDLE);
  assign wr     = accept & req.we & ~addr_err;
  assign rd     = accept & ~req.we;

  // Decode the presented address into a register hit and counter index
  always_comb begin
    hit_ctrl  = 1'b0;
    hit_ovf   = 1'b0;
    hit_mask  = 1'b0;
    hit_evsel = 1'b0;
    hit_count = 1'b0;
    sel_idx   = '0;
    cnt_off   = int'(req.addr) - ADDR_CNT_BASE;
    if (int'(req.addr) == ADDR_CTRL) begin
      hit_ctrl = 1'b1;
    end else if (int'(req.addr) == ADDR_OVF) begin
      hit_ovf = 1'b1;
    end else if (int'(req.addr) == ADDR_MASK) begin
      hit_mask = 1'b1;
    end else if ((cnt_off >= 0) && ((cnt_off >> 1) < NUM_CNT)) begin
      sel_idx   = IDX_W'(cnt_off >> 1);
      hit_count = cnt_off[0];
      hit_evsel = ~cnt_off[0];
    end
    addr_err = ~(hit_ctrl | hit_ovf | hit_mask | hit_evsel | hit_count);
  end

  // Read-data selection for the addressed register
  always_comb begin
    rdata_mux = '0;
    if (hit_ctrl)  rdata_mux = {61'b0, 1'b0, freeze_q, enable_q};
    if (hit_ovf)   rdata_mux[NUM_CNT-1:0] = ovf_q;
    if (hit_mask)  rdata_mux[NUM_CNT-1:0] = mask_q;
    if (hit_evsel) rdata_mux[EVSEL_W-1:0] = evsel_q[sel_idx];
    if (hit_count) rdata_mux[CNT_W-1:0]   = count[sel_idx];
  end

  // FSM next state and the one-cycle response
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          if (rd) rsp_rdata_d = rdata_mux;
          if (wr & hit_ctrl & req.wdata[CTRL_CLR]) begin
            state_d = CLEAR;
            idx_d   = '0;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: state_d = IDLE;
      CLEAR: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CNT - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-counter increment, software-write and sequenced-clear strobes
  always_comb begin
    cnt_inc = '0;
    cnt_we  = '0;
    cnt_clr = '0;
    ev_vec  = '0;
    ev_vec[NUM_EVENTS-1:0] = sampled_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      // EVSEL values past the event vector land on the zero padding
      cnt_inc[i] = enable_q & ev_vec[evsel_q[i]];
      cnt_clr[i] = (state_q == CLEAR) && (idx_q == IDX_W'(i));
    end
    if (wr & hit_count) cnt_we[sel_idx] = 1'b1;
  end

  // Control, overflow, mask and event-select register updates
  always_comb begin
    sampled_d = pmu_sig_i;
    enable_d  = enable_q;
    freeze_d  = freeze_q;
    ovf_d     = ovf_q;
    mask_d    = mask_q;
    evsel_d   = evsel_q;
    irq_d     = |(ovf_q & mask_q);
    if (wr & hit_ctrl) begin
      enable_d = req.wdata[CTRL_EN];
      freeze_d = req.wdata[CTRL_FRZ];
    end
    if (wr & hit_ovf)   ovf_d = ovf_q & ~req.wdata[NUM_CNT-1:0];
    if (wr & hit_mask)  mask_d = req.wdata[NUM_CNT-1:0];
    if (wr & hit_evsel) evsel_d[sel_idx] = req.wdata[EVSEL_W-1:0];
    // A fresh overflow outranks a same-cycle write-1-to-clear
    ovf_d = ovf_d | cnt_ovf;
    // Hardware freeze outranks a same-cycle software enable
    if (freeze_q & (|cnt_ovf)) enable_d = 1'b0;
  end

  // State, control and response registers
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sampled_q   <= '0;
      enable_q    <= 1'b0;
      freeze_q    <= 1'b0;
      ovf_q       <= '0;
      mask_q      <= '0;
      evsel_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sampled_q   <= sampled_d;
      enable_q    <= enable_d;
      freeze_q    <= freeze_d;
      ovf_q       <= ovf_d;
      mask_q      <= mask_d;
      evsel_q     <= evsel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      irq_q       <= irq_d;
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
    lagarto_pmu_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk_i   (clk_i),
      .reset_l (reset_l),
      .inc_i   (cnt_inc[g]),
      .we_i    (cnt_we[g]),
      .wdata_i (req.wdata[CNT_W-1:0]),
      .clr_i   (cnt_clr[g]),
      .count_o (count[g]),
      .ovf_o   (cnt_ovf[g])
    );
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign ovf_irq_o   = irq_q;

endmodule

// File: tb/tb_lagarto_pmu_ctrl.sv
// Bench for lagarto_pmu_ctrl: directed scenarios plus random traffic against
// a register-level reference model; responses are matched from a queue.
module tb_lagarto_pmu_ctrl;

  localparam int NE = 25;
  localparam int NC = 8;

  logic          clk_i = 1'b0;
  logic          reset_l = 1'b1;
  logic [NE-1:0] pmu_sig_i = '0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [4:0]    req_addr_i = '0;
  logic [63:0]   req_wdata_i = '0;
  logic          rsp_valid_o;
  logic [63:0]   rsp_rdata_o;
  logic          rsp_err_o;
  logic          ovf_irq_o;

  lagarto_pmu_ctrl #(
    .NUM_EVENTS(NE), .NUM_CNT(NC), .CNT_W(64), .ADDR_W(5)
  ) dut (
    .clk_i       (clk_i),
    .reset_l     (reset_l),
    .pmu_sig_i   (pmu_sig_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .ovf_irq_o   (ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  longint unsigned cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [63:0]     rdata;
    logic            err;
    longint unsigned due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: software-visible registers plus busy bookkeeping
  longint unsigned mc [NC];
  bit              men, mfrz, mirq, mclr;
  bit [NC-1:0]     movf, mmask;
  int              mevsel [NC];
  bit [NE-1:0]     msamp;
  int              mbusy;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      mc[i] = 0;
      mevsel[i] = 0;
    end
    men = 0; mfrz = 0; mirq = 0; mclr = 0;
    movf = '0; mmask = '0; msamp = '0; mbusy = 0;
  endtask

  task automatic model_resp(input int addr, input bit we, output logic [63:0] rd, output logic err);
    err = 1'b1;
    rd  = '0;
    if (addr <= 2) err = 1'b0;
    for (int i = 0; i < NC; i++)
      if (addr == 8 + 2 * i || addr == 9 + 2 * i) err = 1'b0;
    if (!err && !we) begin
      if (addr == 0) begin rd[0] = men; rd[1] = mfrz; end
      if (addr == 1) rd[NC-1:0] = movf;
      if (addr == 2) rd[NC-1:0] = mmask;
      for (int i = 0; i < NC; i++) begin
        if (addr == 8 + 2 * i) rd = 64'(mevsel[i]);
        if (addr == 9 + 2 * i) rd = mc[i];
      end
    end
  endtask

  task automatic model_step(input bit [NE-1:0] pmu, input bit v, input bit we, input int addr,
                            input logic [63:0] wd);
    bit              acc, en_n, frz_n;
    bit [NC-1:0]     ovfp, ovf_n;
    longint unsigned nc [NC];
    exp_t            e;
    acc = v && (mbusy == 0);
    if (acc) begin
      model_resp(addr, we, e.rdata, e.err);
      e.due = cyc_cnt + 1;
      exp_q.push_back(e);
    end
    ovfp = '0;
    for (int i = 0; i < NC; i++) begin
      nc[i] = mc[i];
      if (mclr && mbusy > 0 && (NC - mbusy) == i) nc[i] = 0;
      else if (acc && we && addr == 9 + 2 * i) nc[i] = wd;
      else if (men && mevsel[i] < NE && msamp[mevsel[i]]) begin
        if (mc[i] == 64'hFFFF_FFFF_FFFF_FFFF) ovfp[i] = 1'b1;
        nc[i] = mc[i] + 1;
      end
    end
    mirq  = |(movf & mmask);
    en_n  = men;
    frz_n = mfrz;
    if (acc && we && addr == 0) begin en_n = wd[0]; frz_n = wd[1]; end
    if (mfrz && ovfp != 0) en_n = 1'b0;
    ovf_n = movf;
    if (acc && we && addr == 1) ovf_n = ovf_n & ~wd[NC-1:0];
    ovf_n = ovf_n | ovfp;
    if (acc && we && addr == 2) mmask = wd[NC-1:0];
    for (int i = 0; i < NC; i++)
      if (acc && we && addr == 8 + 2 * i) mevsel[i] = int'(wd[4:0]);
    mc   = nc;
    men  = en_n;
    mfrz = frz_n;
    movf = ovf_n;
    if (mbusy > 0) mbusy--;
    if (acc) begin
      if (we && addr == 0 && wd[2]) begin mbusy = NC; mclr = 1'b1; end
      else begin mbusy = 1; mclr = 1'b0; end
    end
    msamp = pmu;
  endtask

  // One clock of stimulus, applied at the falling edge
  task automatic cyc(input bit [NE-1:0] pmu, input bit v, input bit we, input int addr,
                     input logic [63:0] wd);
    pmu_sig_i   = pmu;
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = 5'(addr);
    req_wdata_i = wd;
    chk("req_ready", 64'(req_ready_o), 64'(mbusy == 0));
    chk("ovf_irq", 64'(ovf_irq_o), 64'(mirq));
    model_step(pmu, v, we, addr, wd);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input bit [NE-1:0] pmu);
    for (int k = 0; k < n; k++) cyc(pmu, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic wr(input int addr, input logic [63:0] wd, input bit [NE-1:0] pmu);
    cyc(pmu, 1'b1, 1'b1, addr, wd);
    cyc(pmu, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic rd(input int addr, input bit [NE-1:0] pmu);
    cyc(pmu, 1'b1, 1'b0, addr, '0);
    cyc(pmu, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
    chk({tag, "_irq"}, 64'(ovf_irq_o), 64'd0);
  endtask

  // Response monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (rsp_valid_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got rdata %h err %b, expected no response", rsp_rdata_o, rsp_err_o);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_cycle", 64'(cyc_cnt), 64'(e.due));
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", 64'(rsp_err_o), 64'(e.err));
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL rsp_missing: got no response, expected rdata %h err %b", e.rdata, e.err);
      end
    end
  end

  initial begin
    int          a;
    logic [63:0] d;
    model_reset();
    #1 reset_l = 1'b0;
    #1 chk_reset_outputs("por");
    @(negedge clk_i);
    @(negedge clk_i);
    reset_l = 1'b1;

    // Counting the cycle event for 100 cycles
    wr(0, 64'h1, NE'(1));
    idle(100, NE'(1));
    wr(0, 64'h0, NE'(1));
    rd(9, '0);

    // Overflow with freeze and interrupt
    wr(11, 64'hFFFF_FFFF_FFFF_FFFE, '0);
    wr(10, 64'd1, '0);
    wr(2, 64'd2, '0);
    wr(0, 64'd3, '0);
    cyc(NE'(2), 1'b0, 1'b0, 0, '0);
    idle(1, '0);
    cyc(NE'(2), 1'b0, 1'b0, 0, '0);
    idle(3, '0);
    rd(11, '0);
    rd(1, '0);
    rd(0, '0);
    wr(1, 64'd2, '0);
    idle(3, '0);

    // Software enable loses against a same-cycle frozen overflow
    wr(0, 64'd3, '0);
    wr(11, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    cyc(NE'(2), 1'b0, 1'b0, 0, '0);
    cyc('0, 1'b1, 1'b1, 0, 64'd3);
    idle(2, '0);
    rd(0, '0);
    rd(1, '0);
    wr(1, 64'hFF, '0);

    // Reserved address
    rd(4, '0);
    cyc('0, 1'b1, 1'b1, 5, 64'hFFFF);
    idle(1, '0);
    rd(0, '0);
    rd(2, '0);

    // Clear-all with every counter nonzero
    for (int i = 0; i < NC; i++) begin
      wr(9 + 2 * i, 64'(i + 1), '0);
      wr(8 + 2 * i, 64'd31, '0);
    end
    wr(0, 64'd5, '0);
    idle(NC, '0);
    for (int i = 0; i < NC; i++) rd(9 + 2 * i, '0);
    rd(0, '0);

    // Count write coinciding with its own event
    wr(12, 64'd3, '0);
    cyc(NE'(8), 1'b0, 1'b0, 0, '0);
    cyc('0, 1'b1, 1'b1, 13, 64'h1234_5678_9ABC_DEF0);
    idle(2, '0);
    rd(13, '0);

    // Reset in the third clear cycle
    for (int i = 0; i < NC; i++) wr(9 + 2 * i, 64'(100 + i), '0);
    wr(2, 64'hFF, '0);
    cyc('0, 1'b1, 1'b1, 0, 64'd7);
    idle(2, '0);
    reset_l = 1'b0;
    #1 chk_reset_outputs("mid_clear");
    model_reset();
    exp_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    reset_l = 1'b1;
    idle(1, '0);
    rd(0, '0);
    rd(2, '0);
    for (int i = 0; i < NC; i++) rd(9 + 2 * i, '0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      a = $urandom_range(0, 31);
      d = {$urandom, $urandom};
      if (a >= 9 && a <= 23 && a[0] && $urandom_range(0, 3) == 0)
        d = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      if (a == 0) d[2] = ($urandom_range(0, 7) == 0);
      cyc(NE'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
    end

    idle(NC + 4, '0);
    chk("rsp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
